// File: rtl/sargantana_dcache_req_arbiter.sv
// N-requester front end for one HPDCache requester port: round-robin arbitration with one
// high-priority requester, SID tagging, response routing and per-requester outstanding limits.
module sargantana_dcache_req_arbiter #(
    parameter int NREQ            = 3,
    parameter int HIPRI_SID       = 0,
    parameter int MAX_OUTSTANDING = 4,
    parameter int REQ_W           = 128,
    parameter int RSP_W           = 128,
    parameter int TAG_W           = 4,
    localparam int SID_W          = $clog2(NREQ)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NREQ-1:0]         req_valid_i,
    output logic [NREQ-1:0]         req_ready_o,
    input  logic [NREQ*REQ_W-1:0]   req_data_i,
    input  logic [NREQ*TAG_W-1:0]   req_tag_i,
    input  logic [NREQ-1:0]         req_need_rsp_i,
    output logic                    dcache_req_valid_o,
    input  logic                    dcache_req_ready_i,
    output logic [REQ_W-1:0]        dcache_req_data_o,
    output logic [SID_W+TAG_W-1:0]  dcache_req_tag_o,
    input  logic                    dcache_rsp_valid_i,
    input  logic [SID_W+TAG_W-1:0]  dcache_rsp_tag_i,
    input  logic [RSP_W-1:0]        dcache_rsp_data_i,
    output logic [NREQ-1:0]         rsp_valid_o,
    output logic [TAG_W-1:0]        rsp_tag_o,
    output logic [RSP_W-1:0]        rsp_data_o,
    output logic                    idle_o,
    output logic                    err_o
);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    // Handshakes: a transfer happens on a cycle where valid && ready are both high;
    // valid never depends on ready, and payload is held stable while valid && !ready.
    logic                   buf_valid_q;
    logic [REQ_W-1:0]       buf_data_q;
    logic [SID_W+TAG_W-1:0] buf_tag_q;
    logic [SID_W-1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0]       cnt_q [NREQ];
    logic                   err_q;

    logic [NREQ-1:0]  eligible;
    logic [NREQ-1:0]  grant;
    logic [NREQ-1:0]  rsp_hit;
    logic [NREQ-1:0]  dec;
    logic             can_accept;
    logic             any_grant;
    logic             rr_grant;
    logic [SID_W-1:0] gnt_idx;
    logic [SID_W-1:0] rsp_sid;
    logic             sid_ok;
    logic             rsp_to_zero;
    logic             all_zero;

    assign can_accept = !buf_valid_q || dcache_req_ready_i;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            eligible[i] = req_valid_i[i] &&
                          (!req_need_rsp_i[i] || cnt_q[i] < CNT_W'(MAX_OUTSTANDING));
        end
    end

    // HIPRI is never eligible inside the round-robin scan, so it cannot win twice.
    always_comb begin
        int idx;
        grant    = '0;
        rr_grant = 1'b0;
        gnt_idx  = '0;
        idx      = 0;
        if (can_accept) begin
            if (eligible[HIPRI_SID]) begin
                grant[HIPRI_SID] = 1'b1;
                gnt_idx          = SID_W'(HIPRI_SID);
            end else begin
                for (int k = 0; k < NREQ; k++) begin
                    idx = int'(ptr_q) + k;
                    if (idx >= NREQ) idx = idx - NREQ;
                    if (!rr_grant && eligible[idx]) begin
                        rr_grant     = 1'b1;
                        grant[idx]   = 1'b1;
                        gnt_idx      = SID_W'(idx);
                    end
                end
            end
        end
    end

    assign any_grant   = |grant;
    assign req_ready_o = grant;

    always_comb begin
        ptr_d = ptr_q;
        if (rr_grant) begin
            ptr_d = (gnt_idx == SID_W'(NREQ - 1)) ? '0 : gnt_idx + SID_W'(1);
        end
    end

    assign rsp_sid = dcache_rsp_tag_i[TAG_W +: SID_W];
    assign sid_ok  = int'(rsp_sid) < NREQ;

    always_comb begin
        rsp_to_zero = 1'b0;
        all_zero    = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            rsp_hit[i] = dcache_rsp_valid_i && (rsp_sid == SID_W'(i));
            dec[i]     = rsp_hit[i] && (cnt_q[i] != '0);
            if (rsp_hit[i] && cnt_q[i] == '0) rsp_to_zero = 1'b1;
            if (cnt_q[i] != '0) all_zero = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            buf_valid_q <= 1'b0;
            buf_data_q  <= '0;
            buf_tag_q   <= '0;
            ptr_q       <= '0;
            err_q       <= 1'b0;
            for (int i = 0; i < NREQ; i++) cnt_q[i] <= '0;
        end else begin
            if (any_grant) begin
                buf_valid_q <= 1'b1;
                buf_data_q  <= req_data_i[gnt_idx*REQ_W +: REQ_W];
                buf_tag_q   <= {gnt_idx, req_tag_i[gnt_idx*TAG_W +: TAG_W]};
            end else if (dcache_req_ready_i) begin
                buf_valid_q <= 1'b0;
            end
            ptr_q <= ptr_d;
            if (dcache_rsp_valid_i && (!sid_ok || rsp_to_zero)) err_q <= 1'b1;
            for (int i = 0; i < NREQ; i++) begin
                if (grant[i] && req_need_rsp_i[i] && !dec[i]) begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end else if (dec[i] && !(grant[i] && req_need_rsp_i[i])) begin
                    cnt_q[i] <= cnt_q[i] - CNT_W'(1);
                end
            end
        end
    end

    assign dcache_req_valid_o = buf_valid_q;
    assign dcache_req_data_o  = buf_data_q;
    assign dcache_req_tag_o   = buf_tag_q;

    assign rsp_valid_o = rsp_hit;
    assign rsp_tag_o   = dcache_rsp_tag_i[TAG_W-1:0];
    assign rsp_data_o  = dcache_rsp_data_i;

    assign idle_o = !buf_valid_q && all_zero;
    assign err_o  = err_q;

endmodule
